// File: rtl/rv64_regfile.sv
// RV64 integer register file: x0 hardwired to zero, two combinational read ports
// with writeback bypass, and a per-register busy scoreboard for issue tracking.
module rv64_regfile #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      rs1_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic            rs1_busy,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs2_busy,
  input  logic            wen,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic            sb_set,
  input  logic [4:0]      sb_addr,
  output logic [XLEN-1:0] gpr_0,
  output logic [XLEN-1:0] gpr_1,
  output logic [XLEN-1:0] gpr_2,
  output logic [XLEN-1:0] gpr_3,
  output logic [XLEN-1:0] gpr_4,
  output logic [XLEN-1:0] gpr_5,
  output logic [XLEN-1:0] gpr_6,
  output logic [XLEN-1:0] gpr_7,
  output logic [XLEN-1:0] gpr_8,
  output logic [XLEN-1:0] gpr_9,
  output logic [XLEN-1:0] gpr_10,
  output logic [XLEN-1:0] gpr_11,
  output logic [XLEN-1:0] gpr_12,
  output logic [XLEN-1:0] gpr_13,
  output logic [XLEN-1:0] gpr_14,
  output logic [XLEN-1:0] gpr_15,
  output logic [XLEN-1:0] gpr_16,
  output logic [XLEN-1:0] gpr_17,
  output logic [XLEN-1:0] gpr_18,
  output logic [XLEN-1:0] gpr_19,
  output logic [XLEN-1:0] gpr_20,
  output logic [XLEN-1:0] gpr_21,
  output logic [XLEN-1:0] gpr_22,
  output logic [XLEN-1:0] gpr_23,
  output logic [XLEN-1:0] gpr_24,
  output logic [XLEN-1:0] gpr_25,
  output logic [XLEN-1:0] gpr_26,
  output logic [XLEN-1:0] gpr_27,
  output logic [XLEN-1:0] gpr_28,
  output logic [XLEN-1:0] gpr_29,
  output logic [XLEN-1:0] gpr_30,
  output logic [XLEN-1:0] gpr_31
);

  logic [31:1][XLEN-1:0] regs;
  logic [31:1]           busy;
  logic                  wr_live;

  assign wr_live = wen && (waddr != 5'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      regs <= '0;
      busy <= '0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (wr_live && (waddr == 5'(i)))
          regs[i] <= wdata;
        // set has priority so an issue landing on the writeback target stays busy
        if (sb_set && (sb_addr == 5'(i)))
          busy[i] <= 1'b1;
        else if (wr_live && (waddr == 5'(i)))
          busy[i] <= 1'b0;
      end
    end
  end

  function automatic logic [XLEN-1:0] read_reg(input logic [4:0] addr);
    logic [XLEN-1:0] r;
    r = '0;
    for (int i = 1; i < 32; i++)
      if (addr == 5'(i))
        r = regs[i];
    if (wr_live && (waddr == addr))
      r = wdata;
    return r;
  endfunction

  function automatic logic read_busy(input logic [4:0] addr);
    logic b;
    b = 1'b0;
    for (int i = 1; i < 32; i++)
      if (addr == 5'(i))
        b = busy[i];
    // a writeback in flight retires the producer this cycle
    if (wen && (waddr == addr))
      b = 1'b0;
    return b;
  endfunction

  assign rs1_data = read_reg(rs1_addr);
  assign rs2_data = read_reg(rs2_addr);
  assign rs1_busy = read_busy(rs1_addr);
  assign rs2_busy = read_busy(rs2_addr);

  assign gpr_0  = '0;
  assign gpr_1  = regs[1];
  assign gpr_2  = regs[2];
  assign gpr_3  = regs[3];
  assign gpr_4  = regs[4];
  assign gpr_5  = regs[5];
  assign gpr_6  = regs[6];
  assign gpr_7  = regs[7];
  assign gpr_8  = regs[8];
  assign gpr_9  = regs[9];
  assign gpr_10 = regs[10];
  assign gpr_11 = regs[11];
  assign gpr_12 = regs[12];
  assign gpr_13 = regs[13];
  assign gpr_14 = regs[14];
  assign gpr_15 = regs[15];
  assign gpr_16 = regs[16];
  assign gpr_17 = regs[17];
  assign gpr_18 = regs[18];
  assign gpr_19 = regs[19];
  assign gpr_20 = regs[20];
  assign gpr_21 = regs[21];
  assign gpr_22 = regs[22];
  assign gpr_23 = regs[23];
  assign gpr_24 = regs[24];
  assign gpr_25 = regs[25];
  assign gpr_26 = regs[26];
  assign gpr_27 = regs[27];
  assign gpr_28 = regs[28];
  assign gpr_29 = regs[29];
  assign gpr_30 = regs[30];
  assign gpr_31 = regs[31];

endmodule

// File: tb/tb_rv64_regfile.sv
// Bench for rv64_regfile: directed scenarios followed by random traffic compared
// against an array-based architectural model of registers and busy bits.
module tb_rv64_regfile;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic [4:0]      rs1_addr, rs2_addr, waddr, sb_addr;
  logic [XLEN-1:0] rs1_data, rs2_data, wdata;
  logic            rs1_busy, rs2_busy, wen, sb_set;
  logic [XLEN-1:0] gpr [32];

  logic [XLEN-1:0] m_reg  [32];
  bit              m_busy [32];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rv64_regfile #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .rs1_addr(rs1_addr), .rs1_data(rs1_data), .rs1_busy(rs1_busy),
    .rs2_addr(rs2_addr), .rs2_data(rs2_data), .rs2_busy(rs2_busy),
    .wen(wen), .waddr(waddr), .wdata(wdata),
    .sb_set(sb_set), .sb_addr(sb_addr),
    .gpr_0(gpr[0]),   .gpr_1(gpr[1]),   .gpr_2(gpr[2]),   .gpr_3(gpr[3]),
    .gpr_4(gpr[4]),   .gpr_5(gpr[5]),   .gpr_6(gpr[6]),   .gpr_7(gpr[7]),
    .gpr_8(gpr[8]),   .gpr_9(gpr[9]),   .gpr_10(gpr[10]), .gpr_11(gpr[11]),
    .gpr_12(gpr[12]), .gpr_13(gpr[13]), .gpr_14(gpr[14]), .gpr_15(gpr[15]),
    .gpr_16(gpr[16]), .gpr_17(gpr[17]), .gpr_18(gpr[18]), .gpr_19(gpr[19]),
    .gpr_20(gpr[20]), .gpr_21(gpr[21]), .gpr_22(gpr[22]), .gpr_23(gpr[23]),
    .gpr_24(gpr[24]), .gpr_25(gpr[25]), .gpr_26(gpr[26]), .gpr_27(gpr[27]),
    .gpr_28(gpr[28]), .gpr_29(gpr[29]), .gpr_30(gpr[30]), .gpr_31(gpr[31])
  );

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Architectural view of a read: x0 is zero, an in-flight write is forwarded.
  function automatic logic [XLEN-1:0] exp_data(input logic [4:0] a);
    if (a == 0) return '0;
    if (wen && waddr == a) return wdata;
    return m_reg[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (a == 0) return 1'b0;
    if (wen && waddr == a) return 1'b0;
    return m_busy[a];
  endfunction

  // Advance one clock; the model commits the same transaction the DUT sees.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_reg[i]  = '0;
        m_busy[i] = 0;
      end
    end else begin
      if (wen && waddr != 0) begin
        m_reg[waddr]  = wdata;
        m_busy[waddr] = 0;
      end
      if (sb_set && sb_addr != 0) m_busy[sb_addr] = 1;
    end
    #1;
  endtask

  task automatic chk_ports(input string tag);
    chk({tag, ".rs1_data"}, rs1_data, exp_data(rs1_addr));
    chk({tag, ".rs2_data"}, rs2_data, exp_data(rs2_addr));
    chk({tag, ".rs1_busy"}, {63'd0, rs1_busy}, {63'd0, exp_busy(rs1_addr)});
    chk({tag, ".rs2_busy"}, {63'd0, rs2_busy}, {63'd0, exp_busy(rs2_addr)});
  endtask

  task automatic chk_gprs(input string tag);
    for (int i = 0; i < 32; i++)
      chk($sformatf("%s.gpr_%0d", tag, i), gpr[i], m_reg[i]);
  endtask

  task automatic idle();
    rst = 0; wen = 0; waddr = 0; wdata = '0; sb_set = 0; sb_addr = 0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      m_reg[i]  = '0;
      m_busy[i] = 0;
    end
    idle();
    rs1_addr = 0;
    rs2_addr = 0;

    // reset, then sweep every index
    rst = 1;
    tick();
    tick();
    rst = 0;
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i);
      rs2_addr = 5'(i);
      #1;
      chk("rst.rs1_data", rs1_data, '0);
      chk("rst.rs2_data", rs2_data, '0);
      chk("rst.rs1_busy", {63'd0, rs1_busy}, '0);
      chk("rst.rs2_busy", {63'd0, rs2_busy}, '0);
      chk("rst.gpr", gpr[i], '0);
    end

    // same-cycle bypass on x5
    wen = 1; waddr = 5; wdata = 64'hDEADBEEF_00000001; rs1_addr = 5;
    #1;
    chk("byp.rs1_data", rs1_data, 64'hDEADBEEF_00000001);
    chk("byp.gpr5_before", gpr[5], '0);
    tick();
    idle();
    #1;
    chk("byp.gpr5_after", gpr[5], 64'hDEADBEEF_00000001);
    chk("byp.rs1_held", rs1_data, 64'hDEADBEEF_00000001);

    // x0 ignores writes and scoreboard sets
    wen = 1; waddr = 0; wdata = '1; rs1_addr = 0;
    #1;
    chk("x0.rs1_data_wr", rs1_data, '0);
    tick();
    idle();
    sb_set = 1; sb_addr = 0;
    tick();
    idle();
    #1;
    chk("x0.rs1_data", rs1_data, '0);
    chk("x0.rs1_busy", {63'd0, rs1_busy}, '0);
    chk("x0.gpr0", gpr[0], '0);

    // busy timing on x10
    rs2_addr = 10;
    sb_set = 1; sb_addr = 10;
    #1;
    chk("sb.busy_t", {63'd0, rs2_busy}, '0);
    tick();
    idle();
    #1;
    chk("sb.busy_t1", {63'd0, rs2_busy}, 64'd1);
    tick();
    #1;
    chk("sb.busy_t2", {63'd0, rs2_busy}, 64'd1);
    tick();
    wen = 1; waddr = 10; wdata = 64'h0123_4567_89AB_CDEF;
    #1;
    chk("sb.busy_t3_comb", {63'd0, rs2_busy}, '0);
    chk("sb.data_t3", rs2_data, 64'h0123_4567_89AB_CDEF);
    tick();
    idle();
    #1;
    chk("sb.busy_cleared", {63'd0, rs2_busy}, '0);

    // set and clear collide on x7: set wins
    sb_set = 1; sb_addr = 7; wen = 1; waddr = 7; wdata = 64'hA5A5_0000_0000_5A5A;
    rs1_addr = 7;
    tick();
    idle();
    #1;
    chk("col.rs1_busy", {63'd0, rs1_busy}, 64'd1);
    chk("col.rs1_data", rs1_data, 64'hA5A5_0000_0000_5A5A);
    chk("col.gpr7", gpr[7], 64'hA5A5_0000_0000_5A5A);

    // reset mid-operation overrides a write and clears pending busy bits
    wen = 1; waddr = 3; wdata = 64'h55;
    tick();
    idle();
    sb_set = 1; sb_addr = 3;
    tick();
    sb_addr = 4;
    tick();
    idle();
    rs1_addr = 3; rs2_addr = 4;
    #1;
    chk("mid.pre_busy3", {63'd0, rs1_busy}, 64'd1);
    chk("mid.pre_busy4", {63'd0, rs2_busy}, 64'd1);
    chk("mid.pre_gpr3", gpr[3], 64'h55);
    rst = 1; wen = 1; waddr = 3; wdata = 64'h99;
    tick();
    idle();
    #1;
    chk("mid.rs1_data", rs1_data, '0);
    chk("mid.gpr3", gpr[3], '0);
    chk("mid.rs1_busy", {63'd0, rs1_busy}, '0);
    chk("mid.rs2_busy", {63'd0, rs2_busy}, '0);
    chk_gprs("mid");

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      rst     = ($urandom_range(0, 63) == 0);
      wen     = $urandom_range(0, 1) == 1;
      waddr   = 5'($urandom_range(0, 31));
      wdata   = {$urandom, $urandom};
      sb_set  = $urandom_range(0, 1) == 1;
      sb_addr = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
      rs1_addr = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
      rs2_addr = ($urandom_range(0, 7) == 0) ? rs1_addr : 5'($urandom_range(0, 31));
      #1;
      chk_ports("rnd");
      tick();
      if (n % 50 == 49) chk_gprs("rnd");
    end
    idle();
    #1;
    chk_gprs("end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rv64_regfile.md
RV64_REGFILE -- requirements
Module: rv64_regfile

Interface
REQ-001 The block SHALL have parameter XLEN, default 64, register data width; all data ports SHALL be XLEN bits wide.
REQ-002 The block SHALL have port clk, input, 1, sole clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port rs1_addr, input, 5, read port 1 register index.
REQ-005 The block SHALL have port rs1_data, output, XLEN, read port 1 data.
REQ-006 The block SHALL have port rs1_busy, output, 1, read port 1 register has a pending producer.
REQ-007 The block SHALL have port rs2_addr, input, 5, read port 2 register index.
REQ-008 The block SHALL have port rs2_data, output, XLEN, read port 2 data.
REQ-009 The block SHALL have port rs2_busy, output, 1, read port 2 register has a pending producer.
REQ-010 The block SHALL have port wen, input, 1, writeback strobe.
REQ-011 The block SHALL have port waddr, input, 5, writeback register index.
REQ-012 The block SHALL have port wdata, input, XLEN, writeback data.
REQ-013 The block SHALL have port sb_set, input, 1, issue strobe that marks a destination register busy.
REQ-014 The block SHALL have port sb_addr, input, 5, index of the destination register being marked busy.
REQ-015 The block SHALL have ports gpr_0 .. gpr_31, output, XLEN each, architectural register state for the DPI-C export stage.

Function
REQ-016 Register x0 SHALL always read as 0, never be marked busy, and ignore writes and sb_set.
REQ-017 Storage SHALL be 31 XLEN-bit registers (x1..x31); when wen=1 and waddr!=0, reg[waddr] SHALL take wdata on the rising edge.
REQ-018 Reads SHALL be combinational (0-cycle latency): rsN_data = reg[rsN_addr].
REQ-019 Bypass: when wen=1, waddr!=0 and waddr==rsN_addr, rsN_data SHALL equal wdata in the same cycle.
REQ-020 The scoreboard SHALL hold one busy bit per register x1..x31.
REQ-021 sb_set=1 with sb_addr!=0 SHALL set busy[sb_addr] at the next edge.
REQ-022 wen=1 with waddr!=0 SHALL clear busy[waddr] at the next edge.
REQ-023 When set and clear target the same register in the same cycle, set SHALL win and the bit SHALL end at 1.
REQ-024 Setting an already-busy bit, or clearing an already-clear bit, SHALL leave the bit unchanged and SHALL NOT be flagged as an error.
REQ-025 rsN_busy SHALL be busy[rsN_addr] & ~(wen & waddr==rsN_addr), consistent with the bypass.
REQ-026 An sb_set in cycle t SHALL NOT affect rsN_busy until cycle t+1.
REQ-027 Both read ports SHALL be independent; identical addresses SHALL return identical data and busy values.
REQ-028 gpr_N SHALL reflect registered state only, with no bypass, so a write at edge t is visible on gpr_N after edge t; gpr_0 SHALL be constant 0.
REQ-029 No output SHALL depend combinationally on sb_set or sb_addr.

Reset
REQ-030 When rst=1 at an edge, all registers and all busy bits SHALL be cleared to 0, overriding any wen or sb_set in that cycle.
REQ-031 After reset, every rsN_data and every gpr_N SHALL be 0 and every rsN_busy SHALL be 0, unless a same-cycle bypass applies per REQ-019.
REQ-032 Reset asserted mid-operation SHALL discard all pending busy bits; no write SHALL take effect in the reset cycle.

Verification
REQ-033 Bench SHALL drive: rst for 2 cycles, then read all 32 indices -> rs1_data=rs2_data=0, busy=0, all gpr_N=0.
REQ-034 Bench SHALL drive: wen, waddr=5, wdata=0xDEADBEEF_00000001, rs1_addr=5 in the same cycle -> rs1_data=0xDEADBEEF_00000001 that cycle (bypass); gpr_5 changes only after the edge.
REQ-035 Bench SHALL drive: wen, waddr=0, wdata=0xFFFF..FF, then sb_set with sb_addr=0 -> rs1_data(x0)=0, rs1_busy=0, gpr_0=0.
REQ-036 Bench SHALL drive: sb_set with sb_addr=10 in cycle t -> rs2_busy(rs2_addr=10)=0 in cycle t, 1 in t+1; wen with waddr=10 in t+3 -> busy=0 in t+3 (combinational) and the bit is cleared after the edge.
REQ-037 Bench SHALL drive: sb_set with sb_addr=7 and wen with waddr=7 in the same cycle -> busy[7]=1 next cycle and reg[7]=wdata.
REQ-038 Bench SHALL drive: busy bits set on x3 and x4, reg x3=0x55, then rst together with wen, waddr=3, wdata=0x99 -> next cycle reg[3]=0 and busy[3]=busy[4]=0.
